cordic_sequencer: RTL and testbench

- Front-end and back-end controller for the iterative CORDIC vector-mode core.
- Accepts signed I/Q samples through a valid/ready stream and buffers them in a small FIFO.
- Issues one sample at a time to the core by loading I/Q and pulsing the enable. Waits for the core's ready, captures phase (PM) and magnitude (AM), and presents them on a valid/ready output stream.
- Sits between the sample source and the core; the core's 13-bit I/Q/PM/AM ports connect directly.

---
 rtl/cordic_pkg.sv | 37 +++
 rtl/cordic_sample_fifo.sv | 51 +++++
 rtl/cordic_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_cordic_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, constants, FSM state type and saturation helpers
// for the CORDIC sequencer. No ports; imported by cordic_sample_fifo users and
// cordic_sequencer.
package cordic_pkg;

  localparam int DW           = 13;
  localparam logic signed [DW-1:0] PI_Q10 = 13'sd3217;
  localparam int CORE_LATENCY = 15;

  localparam logic signed [DW-1:0] S_MAX = 13'sd4095;
  localparam logic signed [DW-1:0] S_MIN = 13'sh1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Two's-complement negate; the single unrepresentable case -4096 clamps to 4095.
  function automatic logic signed [DW-1:0] sat_neg(input logic signed [DW-1:0] x);
    if (x == S_MIN) return S_MAX;
    return -x;
  endfunction

  // Clamp a DW+1-bit signed value into DW-bit signed range.
  function automatic logic signed [DW-1:0] sat_narrow(input logic signed [DW:0] x);
    logic signed [DW:0] hi;
    logic signed [DW:0] lo;
    hi = {S_MAX[DW-1], S_MAX};
    lo = {S_MIN[DW-1], S_MIN};
    if (x > hi) return S_MAX;
    if (x < lo) return S_MIN;
    return x[DW-1:0];
  endfunction

endpackage

// File: rtl/cordic_sample_fifo.sv
// cordic_sample_fifo: synchronous FIFO holding packed {I,Q} samples.
// Latency: written entry visible at head the cycle after push.
// Backpressure: full_o/empty_o decoded from the registered occupancy count only.
// Ports: CLK, RESET_N (async active-low), push_i/push_dat_i write side,
//        pop_i/head_dat_o read side (head is combinational), full_o, empty_o.
module cordic_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 26
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);

endmodule

// File: rtl/cordic_sequencer.sv
// cordic_sequencer: buffers I/Q samples and runs them one at a time through the
// iterative CORDIC vector-mode core, returning phase/magnitude on a valid/ready stream.
// Latency: 18 cycles push-to-out_valid with a 15-cycle core (19 with pre-rotation).
// Backpressure: in_ready = FIFO not full; a held result blocks issue of the next sample.
// Optional: define CORDIC_SEQ_QUAD_PRE_EN for quadrant pre-rotation (phase range +/-pi).
// Ports: CLK, RESET_N; in_valid/in_ready/in_i/in_q sample input; out_valid/out_ready/
//        out_pm/out_am/out_err result output; cordic_* wire straight to the core.
module cordic_sequencer
  import cordic_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 31
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_pm,
  output logic        [DW-1:0] out_am,
  output logic                 out_err,
  output logic signed [DW-1:0] cordic_i,
  output logic signed [DW-1:0] cordic_q,
  output logic                 cordic_enable,
  input  logic signed [DW-1:0] cordic_pm,
  input  logic        [DW-1:0] cordic_am,
  input  logic                 cordic_ready
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e               state_q, state_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic signed [DW-1:0] cor_i_q, cor_i_d, cor_q_q, cor_q_d;
  logic                 out_vld_q, out_err_q;
  logic signed [DW-1:0] out_pm_q;
  logic [DW-1:0]        out_am_q;

  logic                 fifo_full, fifo_empty, pop, cap, abort;
  logic [2*DW-1:0]      head;
  logic signed [DW-1:0] head_i, head_q;

  logic                 res_vld, res_err;
  logic signed [DW-1:0] res_pm;
  logic [DW-1:0]        res_am;

  cordic_sample_fifo #(.DEPTH(FIFO_DEPTH), .W(2*DW)) u_fifo (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .push_i     (in_valid & in_ready),
    .push_dat_i ({in_i, in_q}),
    .pop_i      (pop),
    .head_dat_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign head_i   = head[2*DW-1:DW];
  assign head_q   = head[DW-1:0];

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    cap     = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: if (!fifo_empty && !out_vld_q) begin
        pop     = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // tmo_q==0 marks the first WAIT cycle; ready then is the previous op's.
        if (tmo_q != '0 && cordic_ready) begin
          cap     = 1'b1;
          state_d = HOLD;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          abort   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: if (out_vld_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cor_i_d = cor_i_q;
    cor_q_d = cor_q_q;
    if (pop) begin
`ifdef CORDIC_SEQ_QUAD_PRE_EN
      // Rotate left-half-plane samples by pi so the core stays in its range.
      cor_i_d = head_i[DW-1] ? sat_neg(head_i) : head_i;
      cor_q_d = head_i[DW-1] ? sat_neg(head_q) : head_q;
`else
      cor_i_d = head_i;
      cor_q_d = head_q;
`endif
    end
  end

`ifdef CORDIC_SEQ_QUAD_PRE_EN
  logic                 neg_q, qpos_q;
  logic                 stg_vld_q, stg_err_q;
  logic signed [DW-1:0] stg_pm_q;
  logic [DW-1:0]        stg_am_q;
  logic signed [DW:0]   pm_ext, pi_ext, pm_wide;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      neg_q     <= 1'b0;
      qpos_q    <= 1'b0;
      stg_vld_q <= 1'b0;
      stg_err_q <= 1'b0;
      stg_pm_q  <= '0;
      stg_am_q  <= '0;
    end else begin
      if (pop) begin
        neg_q  <= head_i[DW-1];
        qpos_q <= !head_q[DW-1];
      end
      stg_vld_q <= cap | abort;
      if (cap) begin
        stg_pm_q  <= cordic_pm;
        stg_am_q  <= cordic_am;
        stg_err_q <= 1'b0;
      end else if (abort) begin
        stg_pm_q  <= '0;
        stg_am_q  <= '0;
        stg_err_q <= 1'b1;
      end
    end
  end

  // Undo the pi pre-rotation toward the half-plane the original Q pointed to.
  assign pm_ext  = {stg_pm_q[DW-1], stg_pm_q};
  assign pi_ext  = {PI_Q10[DW-1], PI_Q10};
  assign pm_wide = qpos_q ? (pm_ext + pi_ext) : (pm_ext - pi_ext);

  assign res_vld = stg_vld_q;
  assign res_err = stg_err_q;
  assign res_am  = stg_am_q;
  assign res_pm  = (neg_q && !stg_err_q) ? sat_narrow(pm_wide) : stg_pm_q;
`else
  assign res_vld = cap | abort;
  assign res_err = abort;
  assign res_am  = cap ? cordic_am : '0;
  assign res_pm  = cap ? cordic_pm : '0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      cor_i_q   <= '0;
      cor_q_q   <= '0;
      out_vld_q <= 1'b0;
      out_err_q <= 1'b0;
      out_pm_q  <= '0;
      out_am_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cor_i_q <= cor_i_d;
      cor_q_q <= cor_q_d;
      // A result only arrives from WAIT, so out regs never change while valid.
      if (res_vld) begin
        out_vld_q <= 1'b1;
        out_err_q <= res_err;
        out_pm_q  <= res_pm;
        out_am_q  <= res_am;
      end else if (out_vld_q && out_ready) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  // Decoded from the state flop so reset drops the strobe asynchronously.
  assign cordic_enable = (state_q == LOAD);
  assign cordic_i      = cor_i_q;
  assign cordic_q      = cor_q_q;
  assign out_valid     = out_vld_q;
  assign out_pm        = out_pm_q;
  assign out_am        = out_am_q;
  assign out_err       = out_err_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// tb_cordic_sequencer: directed bench for cordic_sequencer with a behavioural
// 15-cycle core stub (normal, stale-ready and never-ready modes).
module tb_cordic_sequencer;

`ifdef CORDIC_SEQ_QUAD_PRE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int TIMEOUT_CYC = 31;
  localparam int LAT         = 18 + EXTRA;
  localparam int TMO_LAT     = TIMEOUT_CYC + 2 + EXTRA;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [12:0] in_i = '0;
  logic signed [12:0] in_q = '0;
  logic in_ready, out_valid, out_err, cordic_enable;
  logic signed [12:0] out_pm, cordic_i, cordic_q;
  logic [12:0] out_am;
  logic cordic_ready;
  logic signed [12:0] cordic_pm;
  logic [12:0] cordic_am;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  cordic_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pm(out_pm), .out_am(out_am), .out_err(out_err),
    .cordic_i(cordic_i), .cordic_q(cordic_q), .cordic_enable(cordic_enable),
    .cordic_pm(cordic_pm), .cordic_am(cordic_am), .cordic_ready(cordic_ready)
  );

  // Core stub: ready rises on the 15th edge after the enable is sampled.
  int stub_mode = 0;   // 0 normal, 1 stale ready kept one extra cycle, 2 never ready
  bit stub_echo = 1'b0; // return pm=I, am=Q of the issued sample
  logic signed [12:0] stub_pm = '0;
  logic [12:0] stub_am = '0;
  logic s_busy, s_stale;
  logic [4:0] s_cnt;
  logic signed [12:0] s_i, s_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cordic_ready <= 1'b0; cordic_pm <= '0; cordic_am <= '0;
      s_busy <= 1'b0; s_stale <= 1'b0; s_cnt <= '0; s_i <= '0; s_q <= '0;
    end else if (cordic_enable) begin
      s_busy <= (stub_mode != 2);
      s_cnt  <= 5'd1;
      s_i    <= cordic_i;
      s_q    <= cordic_q;
      if (stub_mode == 1) s_stale <= 1'b1;
      else cordic_ready <= 1'b0;
    end else begin
      if (s_stale) begin
        s_stale <= 1'b0;
        cordic_ready <= 1'b0;
      end
      if (s_busy) begin
        if (s_cnt == 5'd15) begin
          s_busy <= 1'b0;
          cordic_ready <= 1'b1;
          cordic_pm <= stub_echo ? s_i : stub_pm;
          cordic_am <= stub_echo ? s_q : stub_am;
        end else begin
          s_cnt <= s_cnt + 5'd1;
        end
      end
    end
  end

  task automatic push_smp(input logic signed [12:0] i, input logic signed [12:0] q,
                          input int maxc, output bit ok);
    in_valid = 1'b1; in_i = i; in_q = q; ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      if (in_ready) begin
        @(posedge CLK); @(negedge CLK);
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int maxc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    out_ready = 1'b0;
  endtask

  // Push one sample into an idle DUT; report cycles to out_valid and what the core saw.
  task automatic run_one(input logic signed [12:0] i, input logic signed [12:0] q,
                         output logic [12:0] ci, output logic [12:0] cq,
                         output int lat, output int en, output bit ok);
    bit pok;
    push_smp(i, q, 10, pok);
    lat = 0; en = 0; ci = '0; cq = '0; ok = 1'b0;
    while (lat < 100) begin
      if (out_valid) begin ok = pok; break; end
      if (cordic_enable) begin en++; ci = cordic_i; cq = cordic_q; end
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset();
    #2 RESET_N = 1'b0;
    #2;
    total++; if ({in_ready, out_valid, out_err, cordic_enable} !== 4'b1000) begin bad++;
      $display("FAIL reset_ctl: got %b want 1000", {in_ready, out_valid, out_err, cordic_enable}); end
    total++; if ({out_pm, out_am, cordic_i, cordic_q} !== 52'd0) begin bad++;
      $display("FAIL reset_data: got %h want 0", {out_pm, out_am, cordic_i, cordic_q}); end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    total++; if ({in_ready, out_valid, out_err, cordic_enable} !== 4'b1000) begin bad++;
      $display("FAIL post_reset_ctl: got %b want 1000", {in_ready, out_valid, out_err, cordic_enable}); end
  endtask

  task automatic test_single();
    logic [12:0] ci, cq; int lat, en; bit ok;
    stub_mode = 0; stub_echo = 1'b0; stub_pm = 13'sd100; stub_am = 13'd500;
    run_one(13'sd1000, 13'sd200, ci, cq, lat, en, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done: got no result want result"); end
    total++; if (lat != LAT) begin bad++; $display("FAIL single_lat: got %0d want %0d", lat, LAT); end
    total++; if (en != 1) begin bad++; $display("FAIL single_enable_cycles: got %0d want 1", en); end
    total++; if (ci !== 13'd1000 || cq !== 13'd200) begin bad++;
      $display("FAIL single_core_iq: got %0d,%0d want 1000,200", ci, cq); end
    total++; if (out_pm !== 13'sd100 || out_am !== 13'd500 || out_err !== 1'b0) begin bad++;
      $display("FAIL single_result: got pm=%0d am=%0d err=%b want 100 500 0", out_pm, out_am, out_err); end
    take_out();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_release: got %b want 0", out_valid); end
  endtask

  task automatic test_stale_ready();
    logic [12:0] ci, cq; int lat, en; bit ok;
    stub_mode = 1; stub_pm = 13'sd300; stub_am = 13'd400;
    run_one(13'sd10, 13'sd20, ci, cq, lat, en, ok);
    total++; if (!ok || out_pm !== 13'sd300) begin bad++;
      $display("FAIL stale_first: got ok=%b pm=%0d want 1 300", ok, out_pm); end
    take_out();
    stub_pm = 13'sd555; stub_am = 13'd666;
    run_one(13'sd30, 13'sd40, ci, cq, lat, en, ok);
    total++; if (lat != LAT) begin bad++; $display("FAIL stale_lat: got %0d want %0d", lat, LAT); end
    total++; if (out_pm !== 13'sd555 || out_am !== 13'd666) begin bad++;
      $display("FAIL stale_result: got pm=%0d am=%0d want 555 666", out_pm, out_am); end
    take_out();
  endtask

  task automatic test_timeout();
    logic [12:0] ci, cq; int lat, en; bit ok;
    stub_mode = 2;
    run_one(13'sd50, 13'sd60, ci, cq, lat, en, ok);
    total++; if (!ok || lat != TMO_LAT) begin bad++;
      $display("FAIL timeout_lat: got ok=%b lat=%0d want 1 %0d", ok, lat, TMO_LAT); end
    total++; if (out_err !== 1'b1 || out_pm !== 13'sd0 || out_am !== 13'd0) begin bad++;
      $display("FAIL timeout_result: got err=%b pm=%0d am=%0d want 1 0 0", out_err, out_pm, out_am); end
    take_out();
    stub_mode = 0; stub_pm = -13'sd200; stub_am = 13'd77;
    run_one(13'sd300, -13'sd40, ci, cq, lat, en, ok);
    total++; if (!ok || lat != LAT) begin bad++;
      $display("FAIL timeout_next_lat: got ok=%b lat=%0d want 1 %0d", ok, lat, LAT); end
    total++; if (out_err !== 1'b0 || out_pm !== -13'sd200 || out_am !== 13'd77) begin bad++;
      $display("FAIL timeout_next_result: got err=%b pm=%0d am=%0d want 0 -200 77", out_err, out_pm, out_am); end
    take_out();
  endtask

  task automatic test_backpressure();
    logic signed [12:0] ei [5];
    logic signed [12:0] eq [5];
    logic signed [12:0] pm0;
    bit ok, stable;
    int acc;
    stub_mode = 0; stub_echo = 1'b1; out_ready = 1'b0; acc = 0;
    for (int k = 0; k < 5; k++) begin
      ei[k] = 13'(100 * (k + 1) + k);
      eq[k] = 13'(-(50 * k + 3));
      push_smp(ei[k], eq[k], 4, ok);
      if (ok) acc++;
    end
    total++; if (acc != 5) begin bad++; $display("FAIL bp_accepted: got %0d want 5", acc); end
    push_smp(13'sd999, 13'sd999, 6, ok);
    total++; if (ok || in_ready !== 1'b0) begin bad++;
      $display("FAIL bp_full: got accepted=%b in_ready=%b want 0 0", ok, in_ready); end
    wait_out(60, ok);
    pm0 = out_pm; stable = ok;
    repeat (8) begin
      @(negedge CLK);
      if (out_valid !== 1'b1 || out_pm !== pm0) stable = 1'b0;
    end
    total++; if (!stable) begin bad++; $display("FAIL bp_hold: got unstable want stable pm=%0d", pm0); end
    for (int k = 0; k < 5; k++) begin
      wait_out(60, ok);
      total++; if (!ok || out_pm !== ei[k] || out_am !== 13'(eq[k])) begin bad++;
        $display("FAIL bp_order%0d: got ok=%b pm=%0d am=%0d want %0d %0d", k, ok, out_pm, $signed(out_am), ei[k], eq[k]); end
      take_out();
    end
    wait_out(40, ok);
    total++; if (ok) begin bad++; $display("FAIL bp_extra: got extra result want none"); end
    stub_echo = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [12:0] ci, cq; int lat, en; bit ok1, ok2, ok;
    stub_mode = 0; stub_pm = 13'sd11; stub_am = 13'd22;
    // Async strobe drop: reset while the enable is asserted.
    push_smp(13'sd5, 13'sd6, 10, ok1);
    wait_out(1, ok);
    total++; if (cordic_enable !== 1'b1) begin bad++; $display("FAIL rst_load_pre: got %b want 1", cordic_enable); end
    RESET_N = 1'b0; #1;
    total++; if (cordic_enable !== 1'b0) begin bad++; $display("FAIL rst_load_enable: got %b want 0", cordic_enable); end
    @(negedge CLK); RESET_N = 1'b1; @(negedge CLK);
    // Reset in WAIT with a second sample queued.
    push_smp(13'sd700, 13'sd800, 10, ok1);
    push_smp(13'sd900, 13'sd1000, 10, ok2);
    repeat (3) @(negedge CLK);
    total++; if (cordic_i !== 13'sd700 || cordic_enable !== 1'b0) begin bad++;
      $display("FAIL rst_wait_pre: got i=%0d en=%b want 700 0", cordic_i, cordic_enable); end
    RESET_N = 1'b0; #1;
    total++; if ({in_ready, out_valid, out_err, cordic_enable} !== 4'b1000) begin bad++;
      $display("FAIL rst_wait_ctl: got %b want 1000", {in_ready, out_valid, out_err, cordic_enable}); end
    total++; if ({out_pm, out_am, cordic_i, cordic_q} !== 52'd0) begin bad++;
      $display("FAIL rst_wait_data: got %h want 0", {out_pm, out_am, cordic_i, cordic_q}); end
    @(negedge CLK); RESET_N = 1'b1; @(negedge CLK);
    stub_pm = 13'sd33; stub_am = 13'd44;
    run_one(13'sd123, 13'sd45, ci, cq, lat, en, ok);
    total++; if (!ok || lat != LAT || out_pm !== 13'sd33 || out_am !== 13'd44) begin bad++;
      $display("FAIL rst_after: got ok=%b lat=%0d pm=%0d am=%0d want 1 %0d 33 44", ok, lat, out_pm, out_am, LAT); end
    take_out();
    wait_out(40, ok);
    total++; if (ok) begin bad++; $display("FAIL rst_flush: got stale result want none"); end
  endtask

`ifdef CORDIC_SEQ_QUAD_PRE_EN
  task automatic test_quad();
    logic [12:0] ci, cq; int lat, en; bit ok;
    stub_mode = 0; stub_pm = 13'sd0; stub_am = 13'd9;
    run_one(-13'sd1024, 13'sd0, ci, cq, lat, en, ok);
    total++; if (ci !== 13'd1024 || cq !== 13'd0) begin bad++;
      $display("FAIL quad_iq: got %0d,%0d want 1024,0", $signed(ci), $signed(cq)); end
    total++; if (!ok || lat != LAT || out_pm !== 13'sd3217) begin bad++;
      $display("FAIL quad_pm_pos: got ok=%b lat=%0d pm=%0d want 1 %0d 3217", ok, lat, out_pm, LAT); end
    take_out();
    run_one(13'sh1000, 13'sd100, ci, cq, lat, en, ok);
    total++; if (ci !== 13'd4095 || cq !== 13'(-100)) begin bad++;
      $display("FAIL quad_sat_iq: got %0d,%0d want 4095,-100", $signed(ci), $signed(cq)); end
    take_out();
    run_one(-13'sd100, -13'sd50, ci, cq, lat, en, ok);
    total++; if (cq !== 13'd50 || out_pm !== -13'sd3217) begin bad++;
      $display("FAIL quad_pm_neg: got q=%0d pm=%0d want 50 -3217", $signed(cq), out_pm); end
    take_out();
    stub_pm = 13'sd1000;
    run_one(-13'sd5, 13'sd5, ci, cq, lat, en, ok);
    total++; if (out_pm !== 13'sd4095) begin bad++; $display("FAIL quad_pm_sat: got %0d want 4095", out_pm); end
    take_out();
  endtask
`else
  task automatic test_passthru();
    logic [12:0] ci, cq; int lat, en; bit ok;
    stub_mode = 0; stub_pm = -13'sd777; stub_am = 13'd5;
    run_one(-13'sd1024, -13'sd30, ci, cq, lat, en, ok);
    total++; if (ci !== 13'(-1024) || cq !== 13'(-30)) begin bad++;
      $display("FAIL pass_iq: got %0d,%0d want -1024,-30", $signed(ci), $signed(cq)); end
    total++; if (!ok || out_pm !== -13'sd777 || out_am !== 13'd5) begin bad++;
      $display("FAIL pass_pm: got ok=%b pm=%0d am=%0d want 1 -777 5", ok, out_pm, out_am); end
    take_out();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish by 500000");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_single();
    test_stale_ready();
    test_timeout();
    test_backpressure();
    test_reset_mid();
`ifdef CORDIC_SEQ_QUAD_PRE_EN
    test_quad();
`else
    test_passthru();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
